// File: rtl/inst_encoder_pkg.sv
// Shared RV32I definitions: request kinds, base opcodes and the encoder FSM states.
// Also holds the signed-range helper used by the encoder's legality checks.
package RVS192_package;

  typedef enum logic [3:0] {
    ENC_LUI   = 4'd0,
    ENC_AUIPC = 4'd1,
    ENC_JAL   = 4'd2,
    ENC_JALR  = 4'd3,
    ENC_B     = 4'd4,
    ENC_L     = 4'd5,
    ENC_S     = 4'd6,
    ENC_I     = 4'd7,
    ENC_R     = 4'd8,
    ENC_LI    = 4'd9
  } enc_kind_e;

  localparam logic [6:0] LUI_TYPE   = 7'b0110111;
  localparam logic [6:0] AUIPC_TYPE = 7'b0010111;
  localparam logic [6:0] JAL_TYPE   = 7'b1101111;
  localparam logic [6:0] JALR_TYPE  = 7'b1100111;
  localparam logic [6:0] B_TYPE     = 7'b1100011;
  localparam logic [6:0] L_TYPE     = 7'b0000011;
  localparam logic [6:0] S_TYPE     = 7'b0100011;
  localparam logic [6:0] I_TYPE     = 7'b0010011;
  localparam logic [6:0] R_TYPE     = 7'b0110011;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_LI_LO = 1'b1
  } enc_state_e;

  // True when v is the sign extension of its low w bits (bits [31:w-1] all equal).
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << (w - 1);
    return ((v & m) == 32'h0) || ((v & m) == m);
  endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// Synchronous FIFO holding encoded words plus their last-word flag.
// Head reads as zero while empty; a push on a full FIFO is dropped.
module inst_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rptr];

  // NOTE: storage has no reset; occupancy is tracked by r_count and the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clr && !rst) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I field-to-word encoder with LI -> LUI+ADDI expansion, feeding a small output FIFO.
// Illegal requests are consumed without a push and flagged by a one-cycle enc_err pulse.
module inst_encoder
  import RVS192_package::*;
#(
  parameter int INST_LENGTH = 32,
  parameter int DATA_LENGTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_kind,
  input  logic [2:0]             req_funct3,
  input  logic                   req_alt,
  input  logic [4:0]             req_rs1,
  input  logic [4:0]             req_rs2,
  input  logic [4:0]             req_rd,
  input  logic [DATA_LENGTH-1:0] req_imm,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [INST_LENGTH-1:0] inst_out,
  output logic                   inst_last,
  output logic                   enc_err,
  output logic                   busy
);

  enc_state_e             r_state;
  enc_state_e             w_state_nxt;
  logic [INST_LENGTH-1:0] r_pend;
  logic [INST_LENGTH-1:0] w_pend_nxt;
  logic                   r_err;
  logic                   w_err_nxt;

  logic [INST_LENGTH-1:0] w_word;
  logic [INST_LENGTH-1:0] w_pend_word;
  logic                   w_err;
  logic                   w_last;
  logic                   w_li_two;
  logic                   w_shift;
  logic [19:0]            w_li_hi;

  logic                   w_accept;
  logic                   w_push;
  logic [INST_LENGTH:0]   w_push_data;
  logic [INST_LENGTH:0]   w_head;
  logic                   w_full;
  logic                   w_empty;

  assign w_shift = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
  // (imm + 0x800) >> 12 without carrying the unused low bits around.
  assign w_li_hi = req_imm[31:12] + {19'b0, req_imm[11]};

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_word      = '0;
    w_pend_word = '0;
    w_err       = 1'b0;
    w_last      = 1'b1;
    w_li_two    = 1'b0;
    case (req_kind)
      ENC_LUI: begin
        w_err  = (req_imm[11:0] != 12'h0);
        w_word = {req_imm[31:12], req_rd, LUI_TYPE};
      end
      ENC_AUIPC: begin
        w_err  = (req_imm[11:0] != 12'h0);
        w_word = {req_imm[31:12], req_rd, AUIPC_TYPE};
      end
      ENC_JAL: begin
        w_err  = !fits_signed(req_imm, 21) || req_imm[0];
        w_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, JAL_TYPE};
      end
      ENC_JALR: begin
        w_err  = !fits_signed(req_imm, 12);
        w_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, JALR_TYPE};
      end
      ENC_B: begin
        w_err  = !fits_signed(req_imm, 13) || req_imm[0] ||
                 (req_funct3 == 3'b010) || (req_funct3 == 3'b011);
        w_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                  req_imm[4:1], req_imm[11], B_TYPE};
      end
      ENC_L: begin
        w_err  = !fits_signed(req_imm, 12) || (req_funct3 == 3'b011) ||
                 (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        w_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, L_TYPE};
      end
      ENC_S: begin
        w_err  = !fits_signed(req_imm, 12) || (req_funct3 > 3'b010);
        w_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], S_TYPE};
      end
      ENC_I: begin
        if (w_shift) begin
          w_err  = (req_imm[31:5] != 27'h0);
          w_word = {1'b0, req_alt, 5'b0, req_imm[4:0], req_rs1, req_funct3, req_rd, I_TYPE};
        end else begin
          w_err  = !fits_signed(req_imm, 12);
          w_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, I_TYPE};
        end
      end
      ENC_R: begin
        w_word = {1'b0, req_alt, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, R_TYPE};
      end
      ENC_LI: begin
        if (fits_signed(req_imm, 12)) begin
          w_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, I_TYPE};
        end else begin
          w_word      = {w_li_hi, req_rd, LUI_TYPE};
          w_last      = (req_imm[11:0] == 12'h0);
          w_li_two    = !w_last;
          w_pend_word = {req_imm[11:0], req_rd, 3'b000, req_rd, I_TYPE};
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_err_nxt   = 1'b0;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    w_push_data = '0;
    req_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = !w_full && !rst;
        w_accept  = req_valid && req_ready;
        if (w_accept) begin
          if (w_err) begin
            w_err_nxt = 1'b1;
          end else begin
            w_push      = 1'b1;
            w_push_data = {w_last, w_word};
            if (w_li_two) begin
              w_state_nxt = ST_LI_LO;
              w_pend_nxt  = w_pend_word;
            end
          end
        end
      end
      ST_LI_LO: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_data = {1'b1, r_pend};
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_err   <= w_err_nxt;
    end
  end

  inst_fifo #(
    .WIDTH(INST_LENGTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (flush),
    .i_push (w_push),
    .i_data (w_push_data),
    .i_pop  (inst_ready),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign inst_valid = !w_empty;
  assign inst_out   = w_head[INST_LENGTH-1:0];
  assign inst_last  = w_head[INST_LENGTH];
  assign enc_err    = r_err;
  assign busy       = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed cases, backpressure, flush, and a randomized round trip
// through an independent RV32I decoder / LI executor.
module tb_inst_encoder;
  import RVS192_package::*;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, req_alt;
  logic [3:0]  req_kind;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic [31:0] req_imm, inst_out;
  logic        inst_valid, inst_ready, inst_last, enc_err, busy;

  always #5 clk = ~clk;

  inst_encoder #(.INST_LENGTH(32), .DATA_LENGTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_funct3(req_funct3), .req_alt(req_alt), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_rd(req_rd), .req_imm(req_imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
    .inst_last(inst_last), .enc_err(enc_err), .busy(busy)
  );

  typedef struct packed {
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } fields_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] cap_q[$];
  fields_t     exp_q[$];

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) cap_q.push_back({inst_last, inst_out});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic fields_t mk(input logic [3:0] k, input logic [2:0] f3, input logic alt,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] imm);
    fields_t r;
    r.kind = k; r.f3 = f3; r.alt = alt; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.imm = imm;
    return r;
  endfunction

  // Independent RV32I decoder: fields not present in a format read back as zero.
  function automatic fields_t decode(input logic [31:0] w);
    fields_t d;
    d = '0;
    case (w[6:0])
      LUI_TYPE:   begin d.kind = ENC_LUI;   d.rd = w[11:7]; d.imm = {w[31:12], 12'b0}; end
      AUIPC_TYPE: begin d.kind = ENC_AUIPC; d.rd = w[11:7]; d.imm = {w[31:12], 12'b0}; end
      JAL_TYPE: begin
        d.kind = ENC_JAL; d.rd = w[11:7];
        d.imm  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      JALR_TYPE: begin
        d.kind = ENC_JALR; d.rd = w[11:7]; d.rs1 = w[19:15]; d.f3 = w[14:12];
        d.imm  = {{20{w[31]}}, w[31:20]};
      end
      B_TYPE: begin
        d.kind = ENC_B; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f3 = w[14:12];
        d.imm  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      L_TYPE: begin
        d.kind = ENC_L; d.rd = w[11:7]; d.rs1 = w[19:15]; d.f3 = w[14:12];
        d.imm  = {{20{w[31]}}, w[31:20]};
      end
      S_TYPE: begin
        d.kind = ENC_S; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f3 = w[14:12];
        d.imm  = {{20{w[31]}}, w[31:25], w[11:7]};
      end
      I_TYPE: begin
        d.kind = ENC_I; d.rd = w[11:7]; d.rs1 = w[19:15]; d.f3 = w[14:12];
        if (d.f3 == 3'b001 || d.f3 == 3'b101) begin
          d.imm = {27'b0, w[24:20]}; d.alt = w[30];
        end else begin
          d.imm = {{20{w[31]}}, w[31:20]};
        end
      end
      R_TYPE: begin
        d.kind = ENC_R; d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        d.f3 = w[14:12]; d.alt = w[30];
      end
      default: d.kind = 4'hF;
    endcase
    return d;
  endfunction

  // What the decoder should recover from a legal single-word request.
  function automatic fields_t expect_fields(input fields_t r);
    fields_t e;
    e = '0;
    e.kind = r.kind;
    case (r.kind)
      ENC_LUI, ENC_AUIPC, ENC_JAL: begin e.rd = r.rd; e.imm = r.imm; end
      ENC_JALR: begin e.rd = r.rd; e.rs1 = r.rs1; e.imm = r.imm; end
      ENC_B, ENC_S: begin e.rs1 = r.rs1; e.rs2 = r.rs2; e.f3 = r.f3; e.imm = r.imm; end
      ENC_L: begin e.rd = r.rd; e.rs1 = r.rs1; e.f3 = r.f3; e.imm = r.imm; end
      ENC_I: begin
        e.rd = r.rd; e.rs1 = r.rs1; e.f3 = r.f3; e.imm = r.imm;
        if (r.f3 == 3'b001 || r.f3 == 3'b101) e.alt = r.alt;
      end
      ENC_R: begin e.rd = r.rd; e.rs1 = r.rs1; e.rs2 = r.rs2; e.f3 = r.f3; e.alt = r.alt; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic fields_t rand_req();
    fields_t     r;
    logic [31:0] x;
    logic [2:0]  lf3 [5];
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    x = $urandom;
    r.kind = 4'($urandom_range(0, 9));
    r.f3   = 3'($urandom);
    r.alt  = 1'($urandom);
    r.rs1  = 5'($urandom);
    r.rs2  = 5'($urandom);
    r.rd   = 5'($urandom);
    r.imm  = $urandom;
    case (r.kind)
      ENC_LUI, ENC_AUIPC: r.imm[11:0] = 12'h0;
      ENC_JAL: r.imm = {{11{x[20]}}, x[20:1], 1'b0};
      ENC_B: begin
        r.imm = {{19{x[12]}}, x[12:1], 1'b0};
        if (r.f3 == 3'b010 || r.f3 == 3'b011) r.f3 = r.f3 + 3'd2;
      end
      ENC_L: begin r.imm = {{20{x[11]}}, x[11:0]}; r.f3 = lf3[$urandom_range(0, 4)]; end
      ENC_S: begin r.imm = {{20{x[11]}}, x[11:0]}; r.f3 = 3'($urandom_range(0, 2)); end
      ENC_JALR: r.imm = {{20{x[11]}}, x[11:0]};
      ENC_I: begin
        if (r.f3 == 3'b001 || r.f3 == 3'b101) r.imm = {27'b0, x[4:0]};
        else r.imm = {{20{x[11]}}, x[11:0]};
      end
      ENC_LI: begin
        case ($urandom_range(0, 4))
          0: r.imm = x;
          1: r.imm = {{20{x[11]}}, x[11:0]};
          2: r.imm = {x[31:12], 12'h0};
          3: r.imm = {x[31:12], 1'b1, x[10:0]};
          default: r.imm = {20'h7FFFF, 1'b1, x[10:0]};
        endcase
      end
      default: ;
    endcase
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that follows acceptance.
  task automatic drive_req(input fields_t r, input int budget, output bit acc);
    req_kind = r.kind; req_funct3 = r.f3; req_alt = r.alt;
    req_rs1 = r.rs1; req_rs2 = r.rs2; req_rd = r.rd; req_imm = r.imm;
    req_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < budget && !acc; c++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic send(input fields_t r);
    bit acc;
    drive_req(r, 20, acc);
    check("accept", 64'(acc), 64'd1);
  endtask

  task automatic pop_one();
    @(posedge clk); #1 inst_ready = 1'b1;
    @(posedge clk); #1 inst_ready = 1'b0;
  endtask

  // Executes the LI word(s) from x0=0 and compares the register result with the request.
  task automatic check_li(input fields_t r);
    logic signed [31:0] s;
    int                 exp_n;
    logic [32:0]        w0, w1;
    fields_t            d0, d1;
    logic [31:0]        val;
    s = r.imm;
    exp_n = (s >= -2048 && s <= 2047) ? 1 : ((r.imm[11:0] == 12'h0) ? 1 : 2);
    if (cap_q.size() < exp_n) begin
      check("li_words_present", 64'(cap_q.size()), 64'(exp_n));
      return;
    end
    w0 = cap_q.pop_front();
    d0 = decode(w0[31:0]);
    if (d0.kind == ENC_LUI) val = d0.imm;
    else if (d0.kind == ENC_I && d0.f3 == 3'b000 && d0.rs1 == 5'd0) val = d0.imm;
    else val = 32'hDEAD_BEEF ^ r.imm;
    check("li_rd", 64'(d0.rd), 64'(r.rd));
    if (exp_n == 2) begin
      check("li_first_last", 64'(w0[32]), 64'd0);
      w1 = cap_q.pop_front();
      d1 = decode(w1[31:0]);
      check("li_addi_fields", {d1.kind, d1.f3, d1.rs1, d1.rd}, {ENC_I, 3'b000, r.rd, r.rd});
      check("li_second_last", 64'(w1[32]), 64'd1);
      val = val + d1.imm;
    end else begin
      check("li_single_last", 64'(w0[32]), 64'd1);
    end
    check("li_value", 64'(val), 64'(r.imm));
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 200) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    fields_t     r;
    fields_t     err_reqs [3];
    logic [32:0] w;
    bit          acc;
    int          n_acc;

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; inst_ready = 1'b0;
    req_kind = '0; req_funct3 = '0; req_alt = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_imm = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_outputs", {inst_valid, inst_out, inst_last, enc_err, busy}, 64'd0);
    @(posedge clk); #1;

    // ADDI x5, x6, -1
    send(mk(ENC_I, 3'b000, 1'b0, 5'd6, 5'd0, 5'd5, 32'hFFFF_FFFF));
    @(negedge clk);
    check("addi_valid", 64'(inst_valid), 64'd1);
    check("addi_word", 64'(inst_out), 64'hFFF3_0293);
    check("addi_last", 64'(inst_last), 64'd1);
    pop_one();

    // LI x10, 0x12345FFF -> LUI + ADDI
    send(mk(ENC_LI, 3'b000, 1'b0, 5'd0, 5'd0, 5'd10, 32'h1234_5FFF));
    @(negedge clk);
    check("li2_ready_low", 64'(req_ready), 64'd0);
    check("li2_lui", {inst_valid, inst_last, inst_out}, {1'b1, 1'b0, 32'h1234_6537});
    @(posedge clk); #1;
    @(negedge clk);
    check("li2_ready_back", 64'(req_ready), 64'd1);
    pop_one();
    @(negedge clk);
    check("li2_addi", {inst_valid, inst_last, inst_out}, {1'b1, 1'b1, 32'hFFF5_0513});
    pop_one();
    @(negedge clk);
    check("li2_drained", {inst_valid, busy}, 64'd0);
    @(posedge clk); #1;

    // LI with zero low part, and LI with a small value
    send(mk(ENC_LI, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0000_1000));
    @(negedge clk);
    check("li_lui_only", {inst_valid, inst_last, inst_out}, {1'b1, 1'b1, 32'h0000_10B7});
    pop_one();
    @(negedge clk);
    check("li_lui_only_no_addi", 64'(inst_valid), 64'd0);
    @(posedge clk); #1;
    send(mk(ENC_LI, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0000_0007));
    @(negedge clk);
    check("li_small", {inst_valid, inst_last, inst_out}, {1'b1, 1'b1, 32'h0070_0093});
    pop_one();

    // Illegal requests
    err_reqs[0] = mk(ENC_B, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0000_0003);
    err_reqs[1] = mk(ENC_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd2, 32'h0000_0800);
    err_reqs[2] = mk(ENC_S, 3'b011, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0000_0004);
    for (int i = 0; i < 3; i++) begin
      send(err_reqs[i]);
      @(negedge clk);
      check($sformatf("err%0d_pulse", i), {enc_err, inst_valid}, {1'b1, 1'b0});
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("err%0d_clear", i), {enc_err, inst_valid}, {1'b0, 1'b0});
      @(posedge clk); #1;
    end

    // Backpressure: five requests into a four-entry buffer
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive_req(mk(ENC_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd2, 32'(i + 1)), 6, acc);
      check($sformatf("bp_accept%0d", i), 64'(acc), 64'(i < 4));
      if (acc) n_acc++;
    end
    @(negedge clk);
    check("bp_count", 64'(n_acc), 64'd4);
    check("bp_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    cap_q.delete();
    inst_ready = 1'b1;
    wait_idle("bp_drain");
    check("bp_drained_words", 64'(cap_q.size()), 64'd4);
    for (int i = 0; i < 4 && cap_q.size() > 0; i++) begin
      w = cap_q.pop_front();
      check($sformatf("bp_order%0d", i), {w[32], decode(w[31:0])},
            {1'b1, expect_fields(mk(ENC_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd2, 32'(i + 1)))});
    end

    // Randomized round trip through the decoder
    cap_q.delete();
    exp_q.delete();
    for (int i = 0; i < 80; i++) begin
      r = rand_req();
      exp_q.push_back(r);
      send(r);
    end
    wait_idle("rand_drain");
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      if (r.kind == ENC_LI) begin
        check_li(r);
      end else if (cap_q.size() == 0) begin
        check("rand_word_present", 64'd0, 64'd1);
      end else begin
        w = cap_q.pop_front();
        check($sformatf("rand_kind%0d", r.kind), {w[32], decode(w[31:0])}, {1'b1, expect_fields(r)});
      end
    end
    check("rand_no_extra", 64'(cap_q.size()), 64'd0);

    // Flush while the ADDI of an LI is pending
    inst_ready = 1'b0;
    send(mk(ENC_LI, 3'b000, 1'b0, 5'd0, 5'd0, 5'd3, 32'h1234_5FFF));
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_empty", {inst_valid, busy, inst_out}, 64'd0);
    check("flush_ready", 64'(req_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("flush_addi_dropped", 64'(inst_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

RV32I instruction encoder: the inverse of the pipeline's instruction decoder. It accepts field-level instruction requests (kind, funct3, registers, full-width immediate) over a valid/ready handshake, packs them into 32-bit RV32I words, and expands the `LI` pseudo-instruction into `LUI` + `ADDI`. Encoded words are buffered in a small FIFO and presented to the fetch-injection port used by the debug/boot-ROM path.

## Interface

Parameters:

- `INST_LENGTH`, 32: instruction word width.
- `DATA_LENGTH`, 32: immediate width.
- `FIFO_DEPTH`, 4: output buffer entries. Power of two, ≥2.

Ports:

- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `flush` in 1: synchronous clear of the FIFO and FSM. Lower priority than `rst`.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_kind` in 4 (`enc_kind_e`): one of LUI, AUIPC, JAL, JALR, B, L, S, I, R, LI.
- `req_funct3` in 3: funct3 field. Ignored for LUI/AUIPC/JAL/LI.
- `req_alt` in 1: selects funct7 = 0100000 (SUB/SRA/SRAI).
- `req_rs1`, `req_rs2`, `req_rd` in 5 each: register fields.
- `req_imm` in 32: immediate as the decoder produces it (sign-extended value; U-type value has low 12 bits = 0).
- `inst_valid` out 1: FIFO head valid.
- `inst_ready` in 1: consumer pops the head when `inst_valid & inst_ready`.
- `inst_out` out 32: encoded word.
- `inst_last` out 1: head word is the final word of its request.
- `enc_err` out 1: one-cycle pulse flagging an illegal request.
- `busy` out 1: FSM not IDLE, or FIFO not empty.

## Operation

- FSM states:
  - IDLE: `req_ready = !full`, where `full` is the registered count equal to `FIFO_DEPTH`. There is no pop bypass; there is no combinational path from `inst_ready` to `req_ready`.
  - LI_LO: `req_ready = 0`. Pushes the pending `ADDI` when not full, then returns to IDLE.
- Opcodes and field packing follow RV32I exactly. The funct7 field is {0, req_alt, 00000} for R-type and for shift-immediates (funct3 001/101); otherwise the immediate bits occupy it.
- Legality checks: an illegal request is consumed, pushes nothing, and raises `enc_err`.
  - I/L/S/JALR (non-shift): `req_imm[31:11]` all equal.
  - Shift-immediate: `req_imm[31:5] = 0`.
  - B: `req_imm[31:12]` all equal and `req_imm[0] = 0`.
  - JAL: `req_imm[31:20]` all equal and `req_imm[0] = 0`.
  - LUI/AUIPC: `req_imm[11:0] = 0`.
  - L: funct3 ∉ {011, 110, 111}.
  - S: funct3 ∈ {000, 001, 010}.
  - B: funct3 ∉ {010, 011}.
  - JALR: funct3 forced to 000.
- LI expansion:
  - If `req_imm` fits a signed 12-bit value, emit one word: `ADDI rd, x0, imm`.
  - Otherwise compute `hi = (imm + 32'h800)[31:12]` with wrap-around modulo 2^32, and `lo = imm[11:0]`.
  - Emit `LUI rd, hi`. If `lo != 0`, then emit `ADDI rd, rd, sext(lo)`; only the `ADDI` has `inst_last = 1`. If `lo == 0`, only the `LUI` is emitted, with `inst_last = 1`.
- `rd = x0` is legal and encoded as given.
- Simultaneous push and pop on a full FIFO: the push is blocked (ready was 0). On an empty FIFO, the pushed word appears next cycle. Push and pop never bypass combinationally.
- `flush` or `rst` in LI_LO abandons the pending `ADDI`.

## Timing

- Reset and flush values: `req_ready = 0` during `rst`, then 1 from the first cycle after `rst` deasserts (IDLE, empty FIFO). `inst_valid = 0`, `inst_out = 0`, `inst_last = 0`, `enc_err = 0`, `busy = 0`.
- Request accepted in cycle N:
  - First word is in the FIFO at N+1; `inst_valid` rises at N+1 if the FIFO was empty.
  - For a two-word LI, the second word is pushed at edge N+1 (visible at N+2) if not full; otherwise it is held in LI_LO.
  - `enc_err` is high for exactly cycle N+1.
- Throughput: one word per cycle sustained. LI costs 2 cycles of `req_ready`.
- The head is stable while `inst_valid & !inst_ready`.

## Structure

- `RVS192_package` gains:
  - `enc_kind_e`.
  - RV32I opcode constants shared with the decoder (LUI_TYPE…R_TYPE).
  - Encoder FSM enum `enc_state_e`.
- One sub-module, `inst_fifo`: a synchronous FIFO, `INST_LENGTH+1` wide (word plus last flag), `FIFO_DEPTH` deep, with registered count and full/empty flags.
- Encoding is a combinational function in the top module.

## Test plan

- I: `ADDI x5, x6, -1` (I, f3 000, imm FFFFFFFF) → `inst_out = 32'hFFF30293`, `inst_last = 1`, `inst_valid` at N+1.
- LI: `x10 = 32'h12345FFF` → `LUI x10, 0x12346` (`32'h12346537`), then `ADDI x10, x10, -1` (`32'hFFF50513`). `req_ready` low for 1 cycle.
- LI: `32'h00001000` → single `LUI x1, 1` (`32'h000010B7`), `inst_last = 1`. LI with imm 7 → `ADDI x1, x0, 7` only.
- Errors, each giving an `enc_err` pulse at N+1 and no push:
  - B with imm 3 (odd).
  - I with imm `32'h00000800`.
  - S with funct3 011.
- Backpressure: hold `inst_ready = 0` and issue 5 single-word requests → exactly 4 accepted, `req_ready` drops after the 4th push. Release, and the words drain in order.
- Round trip: random legal requests → Decoder on `inst_out` reproduces kind, rs1/rs2/rd and `imm_dec == req_imm`. `flush` mid-LI_LO leaves FIFO empty and `busy = 0` next cycle.
